// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared ALUOp/funct encodings, ALUCtl codes and FSM states for alu_exec_unit.
package alu_exec_pkg;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SLL = 4'b0011;
    localparam logic [3:0] CTL_SRL = 4'b0100;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_MUL = 4'b1000;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_BAD = 4'b1111;
    typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_exec_unit_decode.sv
// alu_decode: combinational ALUOp+Function -> ALUCtl decoder; mult decodes only with ALU_EXEC_UNIT_MULT_EN.
import alu_exec_pkg::*;
module alu_decode (
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_ctl,
    output logic       o_unsupported
);
    always_comb begin
        o_ctl = CTL_BAD;
        case (i_alu_op)
            ALUOP_ADD: o_ctl = CTL_ADD;
            ALUOP_SUB: o_ctl = CTL_SUB;
            ALUOP_RTYPE:
                case (i_funct)
                    FN_ADD:  o_ctl = CTL_ADD;
                    FN_SUB:  o_ctl = CTL_SUB;
                    FN_AND:  o_ctl = CTL_AND;
                    FN_OR:   o_ctl = CTL_OR;
                    FN_SLT:  o_ctl = CTL_SLT;
                    FN_NOR:  o_ctl = CTL_NOR;
                    FN_SLLV: o_ctl = CTL_SLL;
                    FN_SRLV: o_ctl = CTL_SRL;
`ifdef ALU_EXEC_UNIT_MULT_EN
                    FN_MULT: o_ctl = CTL_MUL;
`endif
                    default: o_ctl = CTL_BAD;
                endcase
            default: o_ctl = CTL_BAD;
        endcase
        o_unsupported = (o_ctl == CTL_BAD);
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU with registered output; iterative shift-add multiplier
// and MUL state exist only when ALU_EXEC_UNIT_MULT_EN is defined.
import alu_exec_pkg::*;
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Function,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [3:0]       ALUCtl,
    output logic             Error
);
    logic [3:0]       w_ctl, w_ld_ctl;
    logic             w_unsup, w_accept, w_is_mult, w_idle, w_load, w_mul_done;
    logic [WIDTH-1:0] w_alu, w_mul_res, w_res;
    logic             r_valid, r_zero, r_err;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_ctl;

    alu_decode u_decode (
        .i_alu_op      (ALUOp),
        .i_funct       (Function),
        .o_ctl         (w_ctl),
        .o_unsupported (w_unsup)
    );

    assign InReady   = w_idle && (!r_valid || OutReady);
    assign w_accept  = InValid && InReady;
    assign w_is_mult = (w_ctl == CTL_MUL);
    assign w_load    = (w_accept && !w_is_mult) || w_mul_done;
    assign w_res     = w_mul_done ? w_mul_res : w_alu;
    assign w_ld_ctl  = w_mul_done ? CTL_MUL : w_ctl;

    always_comb begin
        w_alu = '0;
        case (w_ctl)
            CTL_ADD: w_alu = A + B;
            CTL_SUB: w_alu = A - B;
            CTL_AND: w_alu = A & B;
            CTL_OR:  w_alu = A | B;
            CTL_NOR: w_alu = ~(A | B);
            CTL_SLT: w_alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            CTL_SLL: w_alu = A << B[SHW-1:0];
            CTL_SRL: w_alu = A >> B[SHW-1:0];
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_EXEC_UNIT_MULT_EN
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [SHW-1:0]   r_cnt;

    assign w_idle     = (r_state == S_IDLE);
    assign w_mul_res  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH-1));

    always_ff @(posedge Clock)
        r_state <= Reset ? S_IDLE : w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (w_accept && w_is_mult) ? S_MUL : S_IDLE;
            S_MUL:   w_state_nxt = w_mul_done ? S_IDLE : S_MUL;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One multiplier bit per cycle; the last iteration's sum goes straight to the output register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mult) begin
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_mul_res;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign w_idle     = 1'b1;
    assign w_mul_res  = '0;
    assign w_mul_done = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ctl    <= 4'b0000;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ctl    <= w_ld_ctl;
            r_err    <= !w_mul_done && w_unsup;
        end else if (OutReady) begin
            r_valid  <= 1'b0;
        end
    end

    assign OutValid = r_valid;
    assign Result   = r_result;
    assign Zero     = r_zero;
    assign ALUCtl   = r_ctl;
    assign Error    = r_err;
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (power of two, 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from B.
REQ-003 SHALL have port Clock  input  1  sole clock, rising edge; one clock.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port InValid  input  1  operation request valid.
REQ-006 SHALL have port InReady  output  1  unit can accept a request this cycle.
REQ-007 SHALL have ports ALUOp  input  2  main-decoder op class; Function  input  6  R-type funct field.
REQ-008 SHALL have ports A  input  WIDTH  operand A; B  input  WIDTH  operand B.
REQ-009 SHALL have port OutValid  output  1  Result/Zero/ALUCtl/Error hold a completed operation.
REQ-010 SHALL have port OutReady  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have ports Result  output  WIDTH; Zero  output  1  (Result==0); ALUCtl  output  4  decoded control code; Error  output  1  unsupported op.

Function
REQ-012 Request SHALL be accepted on a rising edge where InValid && InReady; ALUOp/Function/A/B sampled only then.
REQ-013 Decode SHALL be: ALUOp 00 -> add 0010; 01 -> sub 0110; 10 -> by Function: 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 101010 slt 0111, 100111 nor 1100, 000100 sllv 0011, 000110 srlv 0100, 011000 mult 1000; ALUOp 11 or any other Function -> unsupported.
REQ-014 Add/sub SHALL wrap modulo 2^WIDTH; slt SHALL compare signed, Result = 1 or 0; sllv/srlv SHALL shift A by B[SHW-1:0], logical.
REQ-015 Single-cycle ops and unsupported ops SHALL load the output register on the acceptance edge; OutValid high the following cycle (latency 1).
REQ-016 Unsupported op SHALL complete with Result=0, ALUCtl=1111, Error=1, Zero=1.
REQ-017 State machine SHALL have states IDLE, MUL; IDLE->MUL on accepted mult; MUL->IDLE after WIDTH iterations, loading the output register.
REQ-018 Mult SHALL be iterative shift-add, one bit per cycle, Result = low WIDTH bits of A*B (unsigned); OutValid high WIDTH+1 cycles after the acceptance edge.
REQ-019 InReady SHALL equal (state==IDLE) && (!OutValid || OutReady); back-to-back single-cycle ops at full throughput when OutReady=1.
REQ-020 Output register SHALL hold all outputs stable while OutValid && !OutReady; OutValid SHALL drop after an OutReady edge unless a new result loads on that same edge.
REQ-021 Zero SHALL be registered with Result and valid only while OutValid.

Reset
REQ-022 Reset SHALL force state IDLE, OutValid=0, Result=0, Zero=0, ALUCtl=0000, Error=0, clear multiplier datapath.
REQ-023 Reset during MUL SHALL abort the operation with no result emitted; InReady=1 the cycle after Reset deasserts.
REQ-024 Reset SHALL override simultaneous acceptance.

Configuration
REQ-025 Macro ALU_EXEC_UNIT_MULT_EN defined: mult (Function 011000) and state MUL SHALL be implemented as REQ-017/018.
REQ-026 Macro undefined: Function 011000 SHALL decode as unsupported (REQ-016), no MUL state or multiplier logic, InReady = !OutValid || OutReady.

Structure
REQ-027 Package alu_exec_pkg SHALL hold ALUOp encodings, funct codes, 4-bit ALUCtl codes and the state enum.
REQ-028 Sub-module alu_decode SHALL be the combinational ALUOp+Function -> ALUCtl/unsupported decoder, instantiated once.

Verification (WIDTH=32, macro defined unless noted)
REQ-029 ALUOp=10, Function=101010, A=0xFFFFFFFF, B=1, OutReady=1 -> next cycle OutValid=1, Result=1, ALUCtl=0111, Zero=0.
REQ-030 Two add requests back-to-back, OutReady=0 -> first result held stable, InReady=0, second accepted only on the cycle after OutReady=1.
REQ-031 Mult A=7, B=6 -> InReady=0 for 32 cycles, OutValid at cycle 33, Result=42, ALUCtl=1000.
REQ-032 ALUOp=10, Function=111111 -> Result=0, ALUCtl=1111, Error=1, Zero=1, latency 1; same for Function=011000 with macro undefined.
REQ-033 Reset asserted 10 cycles into a mult -> OutValid never rises for it, InReady=1 the cycle after Reset deasserts.
REQ-034 srlv A=0x80000000, B=31 -> Result=1; B=0x20 -> Result=0x80000000 (shift by 0).
